// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one synchronous single-port VRAM between a video fetch stream and a
// CPU. Video has strict priority. CPU accesses are serialised: only one CPU
// access is in flight at a time. A wait counter flags CPU starvation.
//
// Optional feature: define VRAM_POSTED_WRITE_EN to add a 1-entry posted CPU
// write buffer. Without it, CPU writes go straight to the RAM when granted.
//
// Ports
//   clk, resetn            pixel clock, asynchronous active-low reset
//   vid_req, vid_addr      video read request (one read per cycle high)
//   vid_valid, vid_rdata   video read return, three cycles after the request
//   cpu_req, cpu_we,       CPU request, held high until cpu_ack
//   cpu_addr, cpu_wdata
//   cpu_ack, cpu_rdata     one-cycle completion pulse; read data with ack
//   cpu_starve             CPU has waited STARVE_LIMIT cycles
//   ram_en, ram_we,        registered RAM port controls
//   ram_addr, ram_wdata
//   ram_rdata              RAM read data, one cycle after the read is issued
//
// CPU handshake: cpu_req is a request held high until the single-cycle
// cpu_ack. A request is accepted at an edge where it is high and no CPU access
// is in flight; the in-flight window ends at the edge closing the ack cycle,
// so a cpu_req still high in the following cycle starts a new access.
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starve,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Return tag travelling alongside a RAM read: tag0 is the cycle the read is
  // on the RAM port, tag1 the cycle its data is on ram_rdata.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  tag_t             tag0;
  tag_t             tag1;
  logic             busy;      // CPU access in flight, grant through ack cycle
  logic             grant;     // CPU request accepted at this edge
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_next;

`ifdef VRAM_POSTED_WRITE_EN
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              drain;

  // Writes only need an empty buffer; reads also need the RAM slot, and
  // waiting for an empty buffer keeps read-after-write ordering.
  always_comb begin
    drain = wb_valid && !vid_req;
    grant = 1'b0;
    if (cpu_req && !busy && !wb_valid) begin
      grant = cpu_we || !vid_req;
    end
  end
`else
  logic wr_ack_d;  // write issued last edge, ack follows

  always_comb begin
    grant = cpu_req && !busy && !vid_req;
  end
`endif

  always_comb begin
    cnt_next = '0;
    if (cpu_req && !grant) begin
      cnt_next = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      vid_valid  <= 1'b0;
      vid_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      cpu_starve <= 1'b0;
      tag0       <= TAG_NONE;
      tag1       <= TAG_NONE;
      busy       <= 1'b0;
      wait_cnt   <= '0;
`ifdef VRAM_POSTED_WRITE_EN
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
`else
      wr_ack_d   <= 1'b0;
`endif
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      tag0   <= TAG_NONE;

      if (vid_req) begin
        ram_en   <= 1'b1;
        ram_addr <= vid_addr;
        tag0     <= TAG_VID;
      end
`ifdef VRAM_POSTED_WRITE_EN
      else if (drain) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= wb_addr;
        ram_wdata <= wb_data;
      end else if (grant && !cpu_we) begin
        ram_en   <= 1'b1;
        ram_addr <= cpu_addr;
        tag0     <= TAG_CPU;
      end

      if (drain) begin
        wb_valid <= 1'b0;
      end
      if (grant && cpu_we) begin
        wb_valid <= 1'b1;
        wb_addr  <= cpu_addr;
        wb_data  <= cpu_wdata;
      end
      // A posted write completes as soon as it is buffered.
      cpu_ack <= (tag1 == TAG_CPU) || (grant && cpu_we);
`else
      else if (grant) begin
        ram_en   <= 1'b1;
        ram_we   <= cpu_we;
        ram_addr <= cpu_addr;
        if (cpu_we) begin
          ram_wdata <= cpu_wdata;
        end
        tag0 <= cpu_we ? TAG_NONE : TAG_CPU;
      end

      wr_ack_d <= grant && cpu_we;
      cpu_ack  <= (tag1 == TAG_CPU) || wr_ack_d;
`endif

      tag1      <= tag0;
      vid_valid <= (tag1 == TAG_VID);
      if (tag1 == TAG_VID) begin
        vid_rdata <= ram_rdata;
      end
      if (tag1 == TAG_CPU) begin
        cpu_rdata <= ram_rdata;
      end

      // grant and cpu_ack never coincide: an ack implies busy.
      if (grant) begin
        busy <= 1'b1;
      end else if (cpu_ack) begin
        busy <= 1'b0;
      end

      wait_cnt   <= cnt_next;
      cpu_starve <= (cnt_next == LIMIT);
    end
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: VRAM address width.
REQ-002 Parameter DATA_W, default 8: VRAM data width.
REQ-003 Parameter STARVE_LIMIT, default 1024: CPU wait cycles before cpu_starve asserts.
REQ-004 clk  in  1  pixel clock; all logic is on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 vid_req  in  1  video fetch request, one read per cycle high.
REQ-007 vid_addr  in  ADDR_W  video read address.
REQ-008 vid_valid  out  1  video read data valid.
REQ-009 vid_rdata  out  DATA_W  video read data.
REQ-010 cpu_req  in  1  CPU request, held high until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read.
REQ-012 cpu_addr  in  ADDR_W  CPU address.
REQ-013 cpu_wdata  in  DATA_W  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack on reads.
REQ-016 cpu_starve  out  1  CPU wait count has reached STARVE_LIMIT.
REQ-017 ram_en, ram_we  out  1 each  RAM port enable and write enable.
REQ-018 ram_addr  out  ADDR_W; ram_wdata  out  DATA_W  RAM address and write data.
REQ-019 ram_rdata  in  DATA_W  synchronous RAM read data, valid one cycle after a read is issued.

Function
REQ-020 At most one RAM access per cycle. All ram_* outputs are registered: inputs sampled at edge t drive the RAM during cycle t+1.
REQ-021 Priority is strict: vid_req sampled high always wins the RAM slot.
REQ-022 Video latency: a vid_req sampled at edge t produces vid_valid high with the matching vid_rdata during cycle t+3. Back-to-back requests return back-to-back, in order.
REQ-023 CPU grant: cpu_req is granted at an edge where vid_req is low and no CPU access is in flight. The in-flight condition lasts from grant through the cpu_ack cycle inclusive.
REQ-024 CPU write granted at edge t: ram_we high in cycle t+1, cpu_ack high in cycle t+2.
REQ-025 CPU read granted at edge t: cpu_ack high with cpu_rdata in cycle t+3.
REQ-026 cpu_req high in the cycle after cpu_ack is treated as a new request; there is never a double issue.
REQ-027 A single return-tag pipeline (2 stages: video/cpu/none) routes ram_rdata. cpu_rdata holds its last value when cpu_ack is low.
REQ-028 Wait counter:
- increments each cycle cpu_req is high and not granted;
- clears on grant, and when cpu_req is low;
- saturates at STARVE_LIMIT.
- cpu_starve = (counter == STARVE_LIMIT), registered.
REQ-029 When vid_req and cpu_req are both sampled high at the same edge, video is issued and the CPU keeps waiting (the counter increments).
REQ-030 Idle cycle: ram_en = 0, ram_we = 0. ram_addr and ram_wdata hold their last values.

Reset
REQ-031 While resetn is low: ram_en, ram_we, vid_valid, cpu_ack and cpu_starve are 0; ram_addr, ram_wdata, vid_rdata and cpu_rdata are 0; the tag pipeline is none; the counter is 0; the in-flight flag and write buffer are cleared.
REQ-032 Reset mid-access drops all in-flight accesses. No vid_valid or cpu_ack is produced for them after reset release.
REQ-033 First grant is possible at the first edge after resetn deasserts.

Configuration
REQ-034 Macro VRAM_POSTED_WRITE_EN controls posted CPU writes.
- Defined: a 1-entry write buffer is present. A CPU write is accepted when the buffer is empty, with cpu_ack in the cycle after acceptance. The buffered write drains at the first edge where vid_req is low. A CPU read is not granted until the buffer is empty (read-after-write ordering). A new write waits while the buffer is full.
- Undefined: no buffer; REQ-024 timing applies.

Verification
REQ-035 Reset release, vid_req high 4 cycles with addresses 0x000..0x003, RAM holding data = address low byte -> vid_valid high cycles 3..6 with data 0x00..0x03.
REQ-036 cpu_req write addr 0x1800, data 0xA5, vid_req low -> ram_we in cycle 1, cpu_ack in cycle 2. A following read of 0x1800 -> cpu_ack with cpu_rdata 0xA5.
REQ-037 vid_req held high 1100 cycles with a CPU read pending -> no CPU grant, cpu_starve high from wait cycle 1024. vid_req drops -> grant at next edge, cpu_starve 0 the cycle after.
REQ-038 vid_req and cpu_req rise together -> video issued first, CPU issued the next vid_req-low edge.
REQ-039 resetn pulsed low for 1 cycle while a CPU read is in flight -> no cpu_ack, all outputs 0.
REQ-040 With VRAM_POSTED_WRITE_EN defined and video busy, write 0x3F to 0x0100 -> cpu_ack next cycle. An immediate read of 0x0100 is withheld until the drain, then returns 0x3F.
